// File: rtl/debouncer_multi.sv
// Multi-channel debouncer with sync, stability count and edge pulses.
// Optional long-press detect: define DEBOUNCER_LONG_PRESS_EN.
module debouncer_multi #(
  parameter int                        CHANNELS       = 4,
  parameter int                        CNT_WIDTH      = 16,
  parameter logic [CNT_WIDTH-1:0]      STABLE_CNT     = 16'hFFFF,
  parameter int                        LONG_CNT_WIDTH = 24,
  parameter logic [LONG_CNT_WIDTH-1:0] LONG_CNT       = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_event,
  output logic [CHANNELS-1:0] long_press
);

  logic [CHANNELS-1:0]  s0;
  logic [CHANNELS-1:0]  s1;
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0]  chg;
  logic [CHANNELS-1:0]  stable;
  logic [CHANNELS-1:0]  upd;
  logic [CHANNELS-1:0]  rise_nxt;
  logic [CHANNELS-1:0]  fall_nxt;

  // Per-channel change, stability and output-update decode
  always_comb begin
    chg    = s0 ^ s1;
    stable = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      stable[i] = (cnt[i] == STABLE_CNT);
    end
    upd      = stable & (s1 ^ out);
    rise_nxt = upd & s1;
    fall_nxt = upd & ~s1;
  end

  // Synchroniser, stability counters, debounced level and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0        <= '0;
      s1        <= '0;
      out       <= '0;
      rise      <= '0;
      fall      <= '0;
      any_event <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s0 <= in;
      s1 <= s0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (chg[i]) begin
          cnt[i] <= '0;
        end else if (!stable[i]) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      out       <= out ^ upd;
      rise      <= rise_nxt;
      fall      <= fall_nxt;
      any_event <= |(rise_nxt | fall_nxt);
    end
  end

`ifdef DEBOUNCER_LONG_PRESS_EN
  logic [LONG_CNT_WIDTH-1:0] hcnt [CHANNELS];
  logic [CHANNELS-1:0]       lp_q;

  // Hold counters: run while pressed, pulse once on reaching LONG_CNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!out[i]) begin
          hcnt[i] <= '0;
        end else if (hcnt[i] != LONG_CNT) begin
          hcnt[i] <= hcnt[i] + 1'b1;
        end
        lp_q[i] <= out[i] && (hcnt[i] == LONG_CNT - 1'b1);
      end
    end
  end

  assign long_press = lp_q;
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi.
// Window-based reference model plus directed and random stimulus.
module tb_debouncer_multi;

  localparam int S  = 3;
  localparam int LC = 10;
`ifdef DEBOUNCER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [3:0] out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_event;
  logic [3:0] long_press;

  int errs;
  int checks;

  debouncer_multi #(
    .CHANNELS      (4),
    .CNT_WIDTH     (4),
    .STABLE_CNT    (4'd3),
    .LONG_CNT_WIDTH(8),
    .LONG_CNT      (8'd10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .out       (out),
    .rise      (rise),
    .fall      (fall),
    .any_event (any_event),
    .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [3:0] hist[$];
  logic [3:0] mout;
  logic [3:0] mrise;
  logic [3:0] mfall;
  logic [3:0] mlp;
  int         rise_k[4];

  task automatic chk(input string tag,
                     input logic [3:0] got,
                     input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] samp(int idx);
    if (idx < 0) return 4'b0000;
    return hist[idx];
  endfunction

  task automatic model_reset();
    hist.delete();
    mout  = '0;
    mrise = '0;
    mfall = '0;
    mlp   = '0;
    for (int c = 0; c < 4; c++) rise_k[c] = -1000;
  endtask

  // out follows the synchronised level once S+1 consecutive
  // synchronised samples agree; pulses mark each change.
  task automatic model_edge(input logic [3:0] v);
    int         k;
    logic [3:0] prev;
    logic       lvl;
    bit         eq;
    hist.push_back(v);
    k     = hist.size() - 1;
    prev  = mout;
    mrise = '0;
    mfall = '0;
    mlp   = '0;
    for (int c = 0; c < 4; c++) begin
      lvl = samp(k - 2)[c];
      eq  = 1'b1;
      for (int j = k - S - 2; j <= k - 2; j++) begin
        if (samp(j)[c] != lvl) eq = 1'b0;
      end
      if (eq && (lvl != mout[c])) begin
        mout[c]  = lvl;
        mrise[c] = lvl;
        mfall[c] = ~lvl;
        if (lvl) rise_k[c] = k;
      end
      if (LP_EN && prev[c] && (k - rise_k[c] == LC)) mlp[c] = 1'b1;
    end
  endtask

  task automatic step(input logic [3:0] v);
    in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    chk("out", out, mout);
    chk("rise", rise, mrise);
    chk("fall", fall, mfall);
    chk("any", {3'b000, any_event}, {3'b000, |(mrise | mfall)});
    chk("lp", long_press, mlp);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out"}, out, 4'b0000);
    chk({tag, "_rise"}, rise, 4'b0000);
    chk({tag, "_fall"}, fall, 4'b0000);
    chk({tag, "_any"}, {3'b000, any_event}, 4'b0000);
    chk({tag, "_lp"}, long_press, 4'b0000);
  endtask

  initial begin
    logic [3:0] cur;
    int         lp_cnt;
    int         prob;
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    in     = 4'b0000;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("rst");

    // 1: quiet after reset
    rst_n = 1'b1;
    repeat (20) step(4'b0000);
    chk("t1_out", out, 4'b0000);

    // 2: clean rise on channel 0, pulse at edge 5
    for (int e = 0; e < 5; e++) step(4'b0001);
    chk("t2_pre", rise, 4'b0000);
    step(4'b0001);
    chk("t2_rise", rise, 4'b0001);
    chk("t2_any", {3'b000, any_event}, 4'b0001);
    chk("t2_out", out, 4'b0001);
    step(4'b0001);
    chk("t2_once", rise, 4'b0000);

    // 3: short pulse on channel 1 is rejected
    repeat (2) step(4'b0011);
    repeat (8) step(4'b0001);
    chk("t3_out1", {3'b000, out[1]}, 4'b0000);

    // 4: channel 2 press, release with mid-window glitch
    repeat (8) step(4'b0101);
    chk("t4_up", {3'b000, out[2]}, 4'b0001);
    repeat (2) step(4'b0001);
    step(4'b0101);
    repeat (8) step(4'b0001);
    chk("t4_down", {3'b000, out[2]}, 4'b0000);

    // 5: simultaneous rise on channels 0 and 3
    repeat (8) step(4'b0000);
    for (int e = 0; e < 5; e++) step(4'b1001);
    step(4'b1001);
    chk("t5_rise", rise, 4'b1001);
    chk("t5_any", {3'b000, any_event}, 4'b0001);
    step(4'b1001);
    chk("t5_once", {3'b000, any_event}, 4'b0000);

    // 5b: async reset while channel 3 is mid-count
    repeat (6) step(4'b0001);
    repeat (2) step(4'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    model_reset();
    in = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;

    // 6: long press, release, press again (input high at release)
    lp_cnt = 0;
    repeat (25) begin
      step(4'b0001);
      lp_cnt += int'(long_press[0]);
    end
    chk("t6_lp1", 4'(lp_cnt), LP_EN ? 4'd1 : 4'd0);
    repeat (8) step(4'b0000);
    lp_cnt = 0;
    repeat (25) begin
      step(4'b0001);
      lp_cnt += int'(long_press[0]);
    end
    chk("t6_lp2", 4'(lp_cnt), LP_EN ? 4'd1 : 4'd0);

    // random phase with varying toggle rates
    cur = 4'b0001;
    for (int b = 0; b < 20; b++) begin
      prob = $urandom_range(2, 40);
      for (int n = 0; n < 150; n++) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(0, prob - 1) == 0) cur[c] = ~cur[c];
        end
        step(cur);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
